// File: rtl/ex_mem_skid_pkg.sv
// rtl/ex_mem_skid_pkg.sv - shared NOP constants and state encoding for the EX/MEM skid stage
// Contents:
//   NOP_REG_ADDR, zeroWord, OP_NOP : zero values, width-cast at the point of use
//   WriteDisable/WriteEnable       : mem_wreg encodings
//   RstEnable                      : asserted level of the active-low rst
//   state_t                        : EMPTY/HALF/FULL; each value equals the occupancy it stands for
package ex_mem_skid_pkg;

    localparam int unsigned NOP_REG_ADDR = 0;
    localparam int unsigned zeroWord     = 0;
    localparam int unsigned OP_NOP       = 0;

    localparam logic WriteDisable = 1'b0;
    localparam logic WriteEnable  = 1'b1;
    localparam logic RstEnable    = 1'b0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/ex_mem_skid_if.sv
// rtl/ex_mem_skid_if.sv - EX/MEM handshake and payload bundle
// Signals:
//   flush                                                   : synchronous kill of held and incoming entries
//   ex_valid/ex_ready + ex_* payload                        : upstream (EX) side
//   mem_valid/mem_ready + mem_* payload                     : downstream (MEM) side
//   occupancy                                               : entries held (0..2)
// Modports:
//   slave  : the skid stage
//   master : the environment driving EX and consuming MEM
interface ex_mem_skid_if #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int OP_W    = 8
) ();
    logic               flush;
    logic               ex_valid;
    logic               ex_ready;
    logic [DATA_W-1:0]  ex_wdata;
    logic [RADDR_W-1:0] ex_wd;
    logic               ex_wreg;
    logic [OP_W-1:0]    ex_aluop;
    logic [DATA_W-1:0]  ex_mem_addr;
    logic [DATA_W-1:0]  ex_reg2;
    logic               mem_valid;
    logic               mem_ready;
    logic [DATA_W-1:0]  mem_wdata;
    logic [RADDR_W-1:0] mem_wd;
    logic               mem_wreg;
    logic [OP_W-1:0]    mem_aluop;
    logic [DATA_W-1:0]  mem_mem_addr;
    logic [DATA_W-1:0]  mem_reg2;
    logic [1:0]         occupancy;

    modport slave (
        input  flush, ex_valid, ex_wdata, ex_wd, ex_wreg, ex_aluop, ex_mem_addr, ex_reg2, mem_ready,
        output ex_ready, mem_valid, mem_wdata, mem_wd, mem_wreg, mem_aluop, mem_mem_addr, mem_reg2,
               occupancy
    );

    modport master (
        output flush, ex_valid, ex_wdata, ex_wd, ex_wreg, ex_aluop, ex_mem_addr, ex_reg2, mem_ready,
        input  ex_ready, mem_valid, mem_wdata, mem_wd, mem_wreg, mem_aluop, mem_mem_addr, mem_reg2,
               occupancy
    );
endinterface

// File: rtl/ex_mem_payload_reg.sv
// rtl/ex_mem_payload_reg.sv - packed payload register with load, NOP-load and async reset
// Ports:
//   clk, rst : clock, asynchronous active-low reset (loads NOP_VAL)
//   load_i   : capture d_i
//   nop_i    : load NOP_VAL, wins over load_i
//   d_i/q_o  : packed payload in/out
module ex_mem_payload_reg
    import ex_mem_skid_pkg::*;
#(
    parameter int           W       = 8,
    parameter logic [W-1:0] NOP_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         nop_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (nop_i) begin
            data_d = NOP_VAL;
        end else if (load_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            data_q <= NOP_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;
endmodule

// File: rtl/ex_mem_skid.sv
// rtl/ex_mem_skid.sv - EX/MEM pipeline register with optional two-entry skid buffer
// Ports:
//   clk, rst : clock, asynchronous active-low reset
//   bus      : ex_mem_skid_if.slave (flush, EX handshake+payload, MEM handshake+payload, occupancy)
// SKID=1 holds up to two entries and ex_ready depends on state only; SKID=0 holds one entry
// and ex_ready passes mem_ready through combinationally.
module ex_mem_skid
    import ex_mem_skid_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int OP_W    = 8,
    parameter int SKID    = 1
) (
    input  logic clk,
    input  logic rst,
    ex_mem_skid_if.slave bus
);
    localparam int PAY_W = 3 * DATA_W + RADDR_W + 1 + OP_W;
    localparam logic [PAY_W-1:0] NOP_PAY = {DATA_W'(zeroWord), RADDR_W'(NOP_REG_ADDR), WriteDisable,
                                            OP_W'(OP_NOP), DATA_W'(zeroWord), DATA_W'(zeroWord)};

    state_t           state_q, state_d;
    logic [PAY_W-1:0] ex_pay, main_q, main_d, skid_q, out_pay;
    logic             accept, consume, mem_valid_w, ex_ready_w;
    logic             main_load, main_from_skid, skid_load, regs_nop;

    assign ex_pay      = {bus.ex_wdata, bus.ex_wd, bus.ex_wreg, bus.ex_aluop, bus.ex_mem_addr, bus.ex_reg2};
    assign mem_valid_w = (state_q != ST_EMPTY);
    assign accept      = bus.ex_valid & ex_ready_w;
    assign consume     = mem_valid_w & bus.mem_ready;

    generate
        if (SKID != 0) begin : g_skid
            assign ex_ready_w = (state_q != ST_FULL);
            ex_mem_payload_reg #(.W(PAY_W), .NOP_VAL(NOP_PAY)) u_skid (
                .clk(clk), .rst(rst), .load_i(skid_load), .nop_i(regs_nop), .d_i(ex_pay), .q_o(skid_q)
            );
        end else begin : g_single
            // One slot: a new entry fits only if the current one leaves this same cycle.
            assign ex_ready_w = !mem_valid_w | bus.mem_ready;
            assign skid_q     = NOP_PAY;
        end
    endgenerate

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        regs_nop       = 1'b0;
        if (bus.flush) begin
            state_d  = ST_EMPTY;
            regs_nop = 1'b1;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d   = ST_HALF;
                        main_load = 1'b1;
                    end
                end
                ST_HALF: begin
                    if (accept && consume) begin
                        main_load = 1'b1;
                    end else if (accept && (SKID != 0)) begin
                        state_d   = ST_FULL;
                        skid_load = 1'b1;
                    end else if (consume) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (consume) begin
                        state_d        = ST_HALF;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign main_d = main_from_skid ? skid_q : ex_pay;

    ex_mem_payload_reg #(.W(PAY_W), .NOP_VAL(NOP_PAY)) u_main (
        .clk(clk), .rst(rst), .load_i(main_load), .nop_i(regs_nop), .d_i(main_d), .q_o(main_q)
    );

    // main keeps stale data after draining to EMPTY, so the outputs are masked to NOP.
    assign out_pay = mem_valid_w ? main_q : NOP_PAY;

    assign {bus.mem_wdata, bus.mem_wd, bus.mem_wreg, bus.mem_aluop, bus.mem_mem_addr, bus.mem_reg2} = out_pay;
    assign bus.mem_valid = mem_valid_w;
    assign bus.ex_ready  = ex_ready_w;
    assign bus.occupancy = state_q;
endmodule

// File: tb/tb_ex_mem_skid.sv
// tb/tb_ex_mem_skid.sv - self-checking bench for ex_mem_skid in SKID=1 and SKID=0 builds
module tb_ex_mem_skid;
    typedef struct packed {
        logic [31:0] wdata;
        logic [4:0]  wd;
        logic        wreg;
        logic [7:0]  aluop;
        logic [31:0] addr;
        logic [31:0] reg2;
    } pay_t;

    localparam pay_t NOP = '0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ex_mem_skid_if ifc0 ();
    ex_mem_skid_if ifc1 ();

    ex_mem_skid #(.DATA_W(32), .RADDR_W(5), .OP_W(8), .SKID(1)) dut0 (.clk(clk), .rst(rst), .bus(ifc0.slave));
    ex_mem_skid #(.DATA_W(32), .RADDR_W(5), .OP_W(8), .SKID(0)) dut1 (.clk(clk), .rst(rst), .bus(ifc1.slave));

    pay_t q0[$];
    pay_t q1[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic pay_t mk_pay(input logic [31:0] w);
        pay_t p;
        p.wdata = w;
        p.wd    = w[4:0] | 5'd1;
        p.wreg  = 1'b1;
        p.aluop = w[7:0] ^ 8'h5a;
        p.addr  = ~w;
        p.reg2  = w + 32'd1;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic drive(input int sel, input bit v, input pay_t p, input bit r, input bit f);
        if (sel == 0) begin
            ifc0.ex_valid = v; ifc0.mem_ready = r; ifc0.flush = f;
            {ifc0.ex_wdata, ifc0.ex_wd, ifc0.ex_wreg, ifc0.ex_aluop, ifc0.ex_mem_addr, ifc0.ex_reg2} = p;
            ifc1.ex_valid = 1'b0; ifc1.mem_ready = 1'b0; ifc1.flush = 1'b0;
        end else begin
            ifc1.ex_valid = v; ifc1.mem_ready = r; ifc1.flush = f;
            {ifc1.ex_wdata, ifc1.ex_wd, ifc1.ex_wreg, ifc1.ex_aluop, ifc1.ex_mem_addr, ifc1.ex_reg2} = p;
            ifc0.ex_valid = 1'b0; ifc0.mem_ready = 1'b0; ifc0.flush = 1'b0;
        end
    endtask

    task automatic observe(input int sel, output logic rdy, output logic mv, output logic [1:0] occ,
                           output pay_t p);
        if (sel == 0) begin
            rdy = ifc0.ex_ready; mv = ifc0.mem_valid; occ = ifc0.occupancy;
            p = {ifc0.mem_wdata, ifc0.mem_wd, ifc0.mem_wreg, ifc0.mem_aluop, ifc0.mem_mem_addr, ifc0.mem_reg2};
        end else begin
            rdy = ifc1.ex_ready; mv = ifc1.mem_valid; occ = ifc1.occupancy;
            p = {ifc1.mem_wdata, ifc1.mem_wd, ifc1.mem_wreg, ifc1.mem_aluop, ifc1.mem_mem_addr, ifc1.mem_reg2};
        end
    endtask

    // Checks visible outputs against the queue model, then advances the model over one edge.
    task automatic step(input int sel, input bit v, input pay_t p, input bit r, input bit f, input string tag);
        logic rdy, mv;
        logic [1:0] occ;
        pay_t obs, head;
        int n;
        bit exp_rdy, acc, con;
        @(negedge clk);
        drive(sel, v, p, r, f);
        #1;
        n    = (sel == 0) ? q0.size() : q1.size();
        head = (n == 0) ? NOP : ((sel == 0) ? q0[0] : q1[0]);
        exp_rdy = (sel == 0) ? (n < 2) : ((n == 0) || r);
        observe(sel, rdy, mv, occ, obs);
        chk({tag, "/ex_ready"}, 128'(rdy), 128'(exp_rdy));
        chk({tag, "/mem_valid"}, 128'(mv), 128'(n != 0));
        chk({tag, "/occupancy"}, 128'(occ), 128'(n));
        chk({tag, "/payload"}, 128'(obs), 128'(head));
        acc = v && exp_rdy;
        con = (n != 0) && r;
        @(posedge clk);
        if (sel == 0) begin
            if (f) q0.delete();
            else begin
                if (con) void'(q0.pop_front());
                if (acc) q0.push_back(p);
            end
        end else begin
            if (f) q1.delete();
            else begin
                if (con) void'(q1.pop_front());
                if (acc) q1.push_back(p);
            end
        end
    endtask

    task automatic reset_check(input int sel, input string tag);
        logic rdy, mv;
        logic [1:0] occ;
        pay_t obs;
        observe(sel, rdy, mv, occ, obs);
        chk({tag, "/ex_ready"}, 128'(rdy), 128'(1));
        chk({tag, "/mem_valid"}, 128'(mv), 128'(0));
        chk({tag, "/occupancy"}, 128'(occ), 128'(0));
        chk({tag, "/payload"}, 128'(obs), 128'(NOP));
    endtask

    initial begin
        drive(0, 1'b0, NOP, 1'b0, 1'b0);
        #3;
        reset_check(0, "reset0");
        reset_check(1, "reset1");
        @(posedge clk); #2 rst = 1'b1;

        for (int i = 1; i <= 4; i++) step(0, 1'b1, mk_pay(32'h11 * i), 1'b1, 1'b0, "stream");
        repeat (2) step(0, 1'b0, NOP, 1'b1, 1'b0, "stream_drain");

        step(0, 1'b1, mk_pay(32'hA1), 1'b0, 1'b0, "skid_a1");
        step(0, 1'b1, mk_pay(32'hA2), 1'b0, 1'b0, "skid_a2");
        step(0, 1'b1, mk_pay(32'hA9), 1'b0, 1'b0, "skid_full_hold");
        repeat (3) step(0, 1'b0, NOP, 1'b1, 1'b0, "skid_drain");

        step(0, 1'b1, mk_pay(32'hC1), 1'b0, 1'b0, "fill_c1");
        step(0, 1'b1, mk_pay(32'hC2), 1'b0, 1'b0, "fill_c2");
        step(0, 1'b1, mk_pay(32'hB3), 1'b1, 1'b1, "flush_full");
        repeat (2) step(0, 1'b0, NOP, 1'b1, 1'b0, "post_flush");
        step(0, 1'b0, NOP, 1'b1, 1'b1, "flush_empty");

        step(0, 1'b1, mk_pay(32'hD1), 1'b0, 1'b0, "pre_reset");
        #2 rst = 1'b0;
        #1;
        reset_check(0, "async_reset");
        q0.delete();
        q1.delete();
        @(posedge clk); #2 rst = 1'b1;
        step(0, 1'b1, mk_pay(32'hE1), 1'b0, 1'b0, "post_reset_acc");
        step(0, 1'b0, NOP, 1'b1, 1'b0, "post_reset_out");
        step(0, 1'b0, NOP, 1'b1, 1'b0, "post_reset_idle");

        for (int i = 0; i < 8; i++) step(1, 1'b1, mk_pay(32'h100 + i), i[0], 1'b0, "noskid_toggle");
        repeat (2) step(1, 1'b0, NOP, 1'b1, 1'b0, "noskid_drain");

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 5000; i++) begin
                step(s, ($urandom_range(0, 9) < 6), mk_pay($urandom), ($urandom_range(0, 9) < 6),
                     ($urandom_range(0, 31) == 0), (s == 0) ? "rand_skid" : "rand_noskid");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
